// File: rtl/bram_rr_arbiter.sv
// Round-robin request/grant arbiter sharing one single-port BRAM between two requesters,
// with a bounded burst lock, a base offset for requester 1 and owner-tagged read return.
module bram_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 9,
  parameter int BASE1    = 128,
  parameter int LOCK_MAX = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [WIDTH-1:0]  r0_din,
  input  logic              r0_we,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [WIDTH-1:0]  r1_din,
  input  logic              r1_we,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [WIDTH-1:0]  rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_din,
  output logic              mem_we,
  input  logic [WIDTH-1:0]  mem_dout
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [7:0]        LOCK_MAX_C = 8'(LOCK_MAX);
  localparam logic [ADDR_W-1:0] BASE1_C    = ADDR_W'(BASE1);

  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] run_q, run_d;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic       gnt0, gnt1;

  // Grant decision and next-state; everything is held off while rst is high.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    run_d      = run_q;
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    rd_pend_d  = 1'b0;
    rd_owner_d = rd_owner_q;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (r0_req && (!r1_req || last_q)) gnt0 = 1'b1;
          else if (r1_req)                   gnt1 = 1'b1;
        end
        OWN0: begin
          if (r0_req && (!r1_req || run_q < LOCK_MAX_C)) gnt0 = 1'b1;
          else if (r1_req)                               gnt1 = 1'b1;
        end
        OWN1: begin
          if (r1_req && (!r0_req || run_q < LOCK_MAX_C)) gnt1 = 1'b1;
          else if (r0_req)                               gnt0 = 1'b1;
        end
        default: ;
      endcase

      if (gnt0) begin
        run_d   = (state_q == OWN0) ? ((run_q == LOCK_MAX_C) ? run_q : run_q + 8'd1) : 8'd1;
        state_d = OWN0;
        last_d  = 1'b0;
      end else if (gnt1) begin
        run_d   = (state_q == OWN1) ? ((run_q == LOCK_MAX_C) ? run_q : run_q + 8'd1) : 8'd1;
        state_d = OWN1;
        last_d  = 1'b1;
      end else begin
        state_d = IDLE;
      end

      // Tag the read so its data returns to whoever issued it.
      if (gnt0 && !r0_we) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = 1'b0;
      end else if (gnt1 && !r1_we) begin
        rd_pend_d  = 1'b1;
        rd_owner_d = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    mem_din  = '0;
    mem_we   = 1'b0;
    if (gnt0) begin
      mem_addr = r0_addr;
      mem_din  = r0_din;
      mem_we   = r0_we;
    end else if (gnt1) begin
      mem_addr = r1_addr + BASE1_C;
      mem_din  = r1_din;
      mem_we   = r1_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      run_q      <= 8'd0;
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      run_q      <= run_d;
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  assign r0_gnt = gnt0;
  assign r1_gnt = gnt1;
  // A read in flight when rst rises is dropped immediately.
  assign r0_rvalid = rd_pend_q && !rd_owner_q && !rst;
  assign r1_rvalid = rd_pend_q &&  rd_owner_q && !rst;
  assign rdata     = mem_dout;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Self-checking bench: vector table for grants/memory mux, plus a scoreboard queue
// of expected read returns checked one cycle after each read beat.
module tb_bram_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       r0_req = 0, r0_we = 0, r1_req = 0, r1_we = 0;
  logic [8:0] r0_addr = 0, r1_addr = 0;
  logic [7:0] r0_din = 0, r1_din = 0;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, mem_we;
  logic [7:0] rdata, mem_din, mem_dout;
  logic [8:0] mem_addr;

  bram_rr_arbiter #(.WIDTH(8), .ADDR_W(9), .BASE1(128), .LOCK_MAX(16)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_din(r0_din), .r0_we(r0_we),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_din(r1_din), .r1_we(r1_we),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  // Bench-side BRAM with registered read.
  logic [7:0] bram [512];
  logic [7:0] shadow [512];
  always @(posedge clk) begin
    if (mem_we) bram[mem_addr] <= mem_din;
    mem_dout <= bram[mem_addr];
  end

  typedef struct {
    logic       rst;
    logic       q0; logic [8:0] a0; logic [7:0] d0; logic w0;
    logic       q1; logic [8:0] a1; logic [7:0] d1; logic w1;
    logic       g0; logic g1; logic [8:0] ma; logic mw; logic [7:0] md;
  } vec_t;

  typedef struct {
    logic       owner;
    logic [7:0] data;
    int         due;
  } rd_t;

  vec_t vecs[$];
  rd_t  sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_chk = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic add(input logic rs,
                     input logic q0, input int a0, input int d0, input logic w0,
                     input logic q1, input int a1, input int d1, input logic w1,
                     input logic g0, input logic g1, input int ma, input logic mw, input int md);
    vec_t v;
    v.rst = rs;
    v.q0 = q0; v.a0 = 9'(a0); v.d0 = 8'(d0); v.w0 = w0;
    v.q1 = q1; v.a1 = 9'(a1); v.d1 = 8'(d1); v.w1 = w1;
    v.g0 = g0; v.g1 = g1; v.ma = 9'(ma); v.mw = mw; v.md = 8'(md);
    vecs.push_back(v);
  endtask

  task automatic step(input vec_t v);
    rd_t e;
    logic er0, er1;
    logic [7:0] ed;
    @(posedge clk);
    #1;
    rst = v.rst;
    r0_req = v.q0; r0_addr = v.a0; r0_din = v.d0; r0_we = v.w0;
    r1_req = v.q1; r1_addr = v.a1; r1_din = v.d1; r1_we = v.w1;
    cyc++;
    n_vec++;
    if (v.rst) sb.delete();
    @(negedge clk);
    er0 = 0; er1 = 0; ed = 0;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      er0 = !e.owner;
      er1 = e.owner;
      ed  = e.data;
    end
    chk("r0_rvalid", int'(r0_rvalid), int'(er0));
    chk("r1_rvalid", int'(r1_rvalid), int'(er1));
    if (er0 || er1) chk("rdata", int'(rdata), int'(ed));
    chk("r0_gnt", int'(r0_gnt), int'(v.g0));
    chk("r1_gnt", int'(r1_gnt), int'(v.g1));
    chk("mem_addr", int'(mem_addr), int'(v.ma));
    chk("mem_we", int'(mem_we), int'(v.mw));
    chk("mem_din", int'(mem_din), int'(v.md));
    if ((v.g0 || v.g1) && !v.mw) begin
      e.owner = v.g1;
      e.data  = shadow[v.ma];
      e.due   = cyc + 1;
      sb.push_back(e);
    end
    if (v.mw) shadow[v.ma] = v.md;
  endtask

  initial begin
    vec_t v;
    for (int i = 0; i < 512; i++) begin
      bram[i]   = 8'(i * 7 + 3);
      shadow[i] = 8'(i * 7 + 3);
    end

    // Reset: grants and a write attempt are suppressed.
    add(1, 1,3,8'h55,1, 1,4,8'h66,1,  0,0,0,0,0);
    add(1, 1,3,8'h55,1, 1,4,8'h66,1,  0,0,0,0,0);
    // Single requester reads 5,6,7.
    add(0, 1,5,0,0, 0,0,0,0,  1,0,5,0,0);
    add(0, 1,6,0,0, 0,0,0,0,  1,0,6,0,0);
    add(0, 1,7,0,0, 0,0,0,0,  1,0,7,0,0);
    add(0, 0,0,0,0, 0,0,0,0,  0,0,0,0,0);
    // Requester 1 base offset and address wrap, then read back.
    add(0, 0,0,0,0, 1,10,8'hA5,1,  0,1,138,1,8'hA5);
    add(0, 0,0,0,0, 1,400,8'h3C,1, 0,1,16,1,8'h3C);
    add(0, 0,0,0,0, 1,10,0,0,      0,1,138,0,0);
    add(0, 0,0,0,0, 0,0,0,0,       0,0,0,0,0);
    // Owner release: r1 takes over the cycle r0 drops, no gap.
    add(0, 1,20,0,0, 0,0,0,0,  1,0,20,0,0);
    add(0, 1,21,0,0, 0,0,0,0,  1,0,21,0,0);
    add(0, 1,22,0,0, 1,1,0,0,  1,0,22,0,0);
    add(0, 0,0,0,0,  1,1,0,0,  0,1,129,0,0);
    add(0, 0,0,0,0,  0,0,0,0,  0,0,0,0,0);
    // Interleaved single-beat reads.
    add(0, 1,0,0,0, 0,0,0,0,  1,0,0,0,0);
    add(0, 0,0,0,0, 1,0,0,0,  0,1,128,0,0);
    add(0, 1,0,0,0, 0,0,0,0,  1,0,0,0,0);
    add(0, 0,0,0,0, 1,0,0,0,  0,1,128,0,0);
    add(0, 0,0,0,0, 0,0,0,0,  0,0,0,0,0);
    // Reset mid-read: outstanding rvalid dropped, contention then goes to r0.
    add(0, 1,9,0,0, 0,0,0,0,  1,0,9,0,0);
    add(1, 1,9,0,0, 1,3,0,0,  0,0,0,0,0);
    add(0, 0,0,0,0, 0,0,0,0,  0,0,0,0,0);
    add(0, 1,2,0,0, 1,3,0,0,  1,0,2,0,0);
    add(0, 0,0,0,0, 0,0,0,0,  0,0,0,0,0);

    foreach (vecs[i]) step(vecs[i]);

    // Burst lock from reset release: 16 grants to r0, 16 to r1, then back to r0.
    v = '{rst:1, q0:1, a0:0, d0:0, w0:0, q1:1, a1:40, d1:0, w1:0,
          g0:0, g1:0, ma:0, mw:0, md:0};
    step(v);
    for (int i = 0; i <= 32; i++) begin
      v.rst = 0;
      v.a0  = 9'(i);
      v.g0  = (i < 16) || (i == 32);
      v.g1  = !v.g0;
      v.ma  = v.g0 ? 9'(i) : 9'd168;
      step(v);
    end
    v = '{rst:0, q0:0, a0:0, d0:0, w0:0, q1:0, a1:0, d1:0, w1:0,
          g0:0, g1:0, ma:0, mw:0, md:0};
    step(v);
    step(v);

    chk("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
- Shares one single-port BRAM (1-cycle registered read) between two requesters: the UART command handler and the message core.
- Replaces the fixed state-based address/data mux with a request/grant arbiter.
- Uses round-robin arbitration with a bounded burst lock, adds a per-requester base offset, and routes read-data-valid back to the requester that issued the read.

Parameters:
- WIDTH, 8, data width of BRAM and requester ports
- ADDR_W, 9, address width (requester and memory side)
- BASE1, 128, offset added to requester 1 addresses (requester 0 offset is 0)
- LOCK_MAX, 16, max consecutive grants to one owner while the other is requesting (1..255)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- r0_req  in  1  requester 0 access request (one beat per granted cycle)
- r0_addr  in  ADDR_W  requester 0 address
- r0_din  in  WIDTH  requester 0 write data
- r0_we  in  1  requester 0 write enable (1=write, 0=read)
- r0_gnt  out  1  requester 0 granted this cycle (combinational)
- r0_rvalid  out  1  read data for requester 0 valid on rdata
- r1_req, r1_addr, r1_din, r1_we, r1_gnt, r1_rvalid: same as above, for requester 1
- rdata  out  WIDTH  shared read data (= mem_dout)
- mem_addr  out  ADDR_W  BRAM address
- mem_din  out  WIDTH  BRAM write data
- mem_we  out  1  BRAM write enable
- mem_dout  in  WIDTH  BRAM read data (valid one cycle after address)

Behaviour:
- Beat = cycle with rX_req=1 and rX_gnt=1. The access is issued to the BRAM in that same cycle. Requesters hold addr/din/we stable while req=1 and gnt=0.
- Grant rule: at most one gnt per cycle, and gnt=0 whenever req=0.
- FSM states: IDLE, OWN0, OWN1. Registers: last (last owner, for priority), run (consecutive-beat counter, saturating at LOCK_MAX).
- IDLE:
  - Only one requester active -> grant it.
  - Both active -> grant the requester != last.
  - Next state is OWNx for the granted x, run=1, last=x.
- OWNx, with y = the other requester:
  - x req and (y idle or run<LOCK_MAX) -> grant x, stay OWNx, run++ (saturating).
  - Otherwise, y req -> grant y, go to OWNy, run=1, last=y.
  - Otherwise (neither requests) -> no grant, go to IDLE (run kept, last kept).
- Memory mux:
  - Beat for 0: mem_addr=r0_addr, mem_din=r0_din, mem_we=r0_we.
  - Beat for 1: mem_addr=(r1_addr+BASE1) mod 2^ADDR_W (wraps, no error), mem_din=r1_din, mem_we=r1_we.
  - No beat: mem_addr=0, mem_din=0, mem_we=0.
- Read return:
  - A read beat at cycle t -> rX_rvalid=1 at cycle t+1 only, with rdata=mem_dout.
  - A write beat produces no rvalid.
  - Back-to-back reads give 1 read per cycle. Alternating owners is legal: each rvalid is tagged by a registered owner bit, so the two rvalids never assert together.
- Simultaneous request on reset-release cycle: priority goes to r0 (last resets to 1).
- Reset values:
  - State=IDLE, last=1, run=0, r0_rvalid=r1_rvalid=0.
  - gnt outputs, mem_we, mem_addr and mem_din are forced 0 while rst=1.
- Reset mid-operation: any outstanding rvalid is dropped, with no rvalid in the cycle after rst. A write beat coincident with rst is suppressed (mem_we=0).
- Latency: grant is 0 cycles after req when the arbiter is free; read data arrives 1 cycle after the grant.
- Starvation bound: a requesting y waits at most LOCK_MAX cycles.

Test Plan:
1. Single requester: r0 reads addr 5, 6, 7 with req held 3 cycles -> r0_gnt=1 for 3 cycles, mem_addr=5,6,7; r0_rvalid on the following 3 cycles with rdata equal to preloaded mem[5..7]; r1_rvalid stays 0.
2. Base offset and wrap: r1 writes 0xA5 to addr 10, then r1 writes to addr 400 -> mem_addr=138 with mem_we=1 and mem_din=0xA5, then mem_addr=(400+128) mod 512=16.
3. Reset-release contention: r0 and r1 both assert req on the first cycle after rst -> r0 granted first. With both held, r0 is granted exactly 16 consecutive cycles, then r1 is granted for the next 16.
4. Owner release: r0 bursts 3 beats and drops req while r1 requests from cycle 2 -> r1_gnt rises in the cycle r0_req falls, with no idle gap; rvalids follow the correct owners with no overlap.
5. Interleaved reads: r0 and r1 single-beat reads alternating each cycle (r0 addr 0, r1 addr 0) -> rvalid alternates 0,1,0,1 with rdata=mem[0] then mem[128].
6. Reset mid-read: r0 read beat at cycle t, rst=1 at t+1 -> r0_rvalid=0 at t+1 and t+2, state IDLE, next contention goes to r0.
